// File: rtl/mips_defs.sv
`default_nettype none
// mips_defs: types and constants shared by the fetch-address sequencer.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } redir_src_t;

endpackage
`default_nettype wire

// File: rtl/pc_range_chk.sv
`default_nettype none
// pc_range_chk: flags an address as legal when it is word aligned and
// inside the IM window [RESET_PC, RESET_PC + 4*IM_WORDS).
module pc_range_chk
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = 1024
) (
  input  logic [31:0] addr,
  output logic        legal
);

  // The 33-bit window end keeps a wrapped 32-bit sum from aliasing into range.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(WORD_BYTES * IM_WORDS);

  always_comb begin
    legal = (addr[1:0] == 2'b00) && (addr >= RESET_PC) && ({1'b0, addr} < WIN_END);
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: next-PC controller with priority redirects, stall hold,
// redirect-under-stall memory and halt on illegal fetch address.
module pc_sequencer
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        j_req,
  input  logic [31:0] j_target,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        addr_err,
  output logic [15:0] redirect_cnt
);

  seq_state_t  state, state_nxt;
  redir_src_t  src;
  logic [31:0] pend_target, pend_nxt, pc_nxt, pc_plus4, req_target, sel_target;
  logic        any_req, load, sel_legal, seq_legal, do_redirect;

  always_comb begin
    src        = SRC_SEQ;
    req_target = 32'd0;
    if (jr_req) begin
      src        = SRC_JR;
      req_target = jr_target;
    end else if (j_req) begin
      src        = SRC_J;
      req_target = j_target;
    end else if (br_req) begin
      src        = SRC_BR;
      req_target = br_target;
    end
  end

  assign any_req    = (src != SRC_SEQ);
  // A fresh request in the release cycle takes precedence over the pending one.
  assign sel_target = (state == PEND && !any_req) ? pend_target : req_target;
  assign load       = !stall && ((state == RUN && any_req) || state == PEND);
  assign pc_plus4   = pc + 32'd4;

  pc_range_chk #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) u_chk_target (
    .addr  (sel_target),
    .legal (sel_legal)
  );

  pc_range_chk #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) u_chk_seq (
    .addr  (pc_plus4),
    .legal (seq_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pend_target  <= 32'd0;
      pc_valid     <= 1'b1;
      redirect     <= 1'b0;
      addr_err     <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_nxt;
      redirect    <= do_redirect;
      pc_valid    <= (state_nxt != HALT);
      addr_err    <= (state_nxt == HALT);
      if (do_redirect && redirect_cnt != 16'hFFFF) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (stall) begin
          if (any_req) state_nxt = PEND;
        end else if (load) begin
          if (!sel_legal) state_nxt = HALT;
        end else if (!seq_legal) begin
          state_nxt = HALT;
        end
      end
      PEND: begin
        if (!stall) state_nxt = sel_legal ? RUN : HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    pc_nxt      = pc;
    pend_nxt    = pend_target;
    do_redirect = 1'b0;
    if (state == RUN || state == PEND) begin
      if (stall) begin
        if (any_req) pend_nxt = req_target;
      end else if (load) begin
        if (sel_legal) begin
          pc_nxt      = sel_target;
          do_redirect = 1'b1;
        end
      end else if (seq_legal) begin
        pc_nxt = pc_plus4;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: directed and random stimulus against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          WORDS  = 1024;

  logic        clk = 1'b0;
  logic        reset, stall, br_req, j_req, jr_req;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] pc;
  logic        pc_valid, redirect, addr_err;
  logic [15:0] redirect_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_valid, m_redir, m_err, m_halt, m_pend;
  logic [31:0] m_ptgt;
  int          m_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC), .IM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_req(br_req), .br_target(br_target),
    .j_req(j_req), .j_target(j_target),
    .jr_req(jr_req), .jr_target(jr_target),
    .pc(pc), .pc_valid(pc_valid), .redirect(redirect),
    .addr_err(addr_err), .redirect_cnt(redirect_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(RST_PC);
    hi = lo + 4 * WORDS;
    return (a % 4 == 0) && (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  task automatic model_edge();
    logic [31:0] tgt;
    bit          req, load;
    if (reset) begin
      m_pc = RST_PC; m_halt = 0; m_redir = 0; m_cnt = 0; m_pend = 0; m_ptgt = 0;
    end else if (m_halt) begin
      m_redir = 0;
    end else begin
      req  = jr_req || j_req || br_req;
      tgt  = jr_req ? jr_target : (j_req ? j_target : br_target);
      m_redir = 0;
      if (stall) begin
        if (req) begin m_pend = 1; m_ptgt = tgt; end
      end else begin
        load = req || m_pend;
        if (!req) tgt = m_ptgt;
        m_pend = 0;
        if (load) begin
          if (is_legal(tgt)) begin
            m_pc = tgt; m_redir = 1;
            if (m_cnt < 65535) m_cnt++;
          end else m_halt = 1;
        end else if (is_legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
        else m_halt = 1;
      end
    end
    m_valid = !m_halt;
    m_err   = m_halt;
  endtask

  // one clock: drive, edge, model, sample 1 time unit later
  task automatic step(input bit rs, input bit st,
                      input bit b, input logic [31:0] bt,
                      input bit jj, input logic [31:0] jt,
                      input bit r, input logic [31:0] rt);
    reset = rs; stall = st;
    br_req = b; br_target = bt;
    j_req = jj; j_target = jt;
    jr_req = r; jr_target = rt;
    @(posedge clk);
    model_edge();
    #1;
    check("pc", pc, m_pc);
    check("pc_valid", 32'(pc_valid), 32'(m_valid));
    check("redirect", 32'(redirect), 32'(m_redir));
    check("addr_err", 32'(addr_err), 32'(m_err));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    step(0, st, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return RST_PC + 32'(4 * $urandom_range(0, WORDS - 1));
    if (k == 7) return RST_PC + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
    if (k == 8) return RST_PC + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    m_pc = 0; m_valid = 0; m_redir = 0; m_err = 0; m_halt = 0; m_pend = 0; m_ptgt = 0; m_cnt = 0;
    reset = 1; stall = 0; br_req = 0; j_req = 0; jr_req = 0;
    br_target = 0; j_target = 0; jr_target = 0;
    @(negedge clk);

    // reset and free run
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_pc", pc, 32'h3000);
    idle(0); check("seq1", pc, 32'h3004);
    idle(0); check("seq2", pc, 32'h3008);
    step(0, 0, 1, 32'h3100, 0, 0, 0, 0);
    check("br_pc", pc, 32'h3100);
    check("br_redir", 32'(redirect), 32'd1);
    idle(0); check("br_next", pc, 32'h3104);
    check("br_cnt", 32'(redirect_cnt), 32'd1);

    // priority
    step(0, 0, 1, 32'h3400, 1, 32'h3300, 1, 32'h3200);
    check("prio", pc, 32'h3200);

    // redirect under stall
    step(0, 1, 0, 0, 1, 32'h3040, 0, 0);
    idle(1); idle(1);
    check("stall_hold", pc, 32'h3200);
    idle(0);
    check("pend_apply", pc, 32'h3040);
    check("pend_redir", 32'(redirect), 32'd1);
    idle(0); check("pend_once", 32'(redirect), 32'd0);

    // illegal latched then overwritten: no halt
    step(0, 1, 1, 32'h3102, 0, 0, 0, 0);
    step(0, 1, 1, 32'h3120, 0, 0, 0, 0);
    idle(0); check("pend_overwrite", pc, 32'h3120);
    // release-cycle request beats pending target
    step(0, 1, 1, 32'h3500, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h3600);
    check("release_req", pc, 32'h3600);

    // misaligned target halts
    step(0, 0, 1, 32'h3102, 0, 0, 0, 0);
    check("mis_hold", pc, 32'h3600);
    check("mis_err", 32'(addr_err), 32'd1);
    step(0, 0, 0, 0, 1, 32'h3010, 0, 0);
    check("halt_ignore", pc, 32'h3600);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_exit", 32'(addr_err), 32'd0);
    // out-of-window target halts
    step(0, 0, 1, 32'h4000, 0, 0, 0, 0);
    check("oow_valid", 32'(pc_valid), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // sequential run off window end
    step(0, 0, 0, 0, 1, 32'h3FFC, 0, 0);
    idle(0);
    check("end_err", 32'(addr_err), 32'd1);
    check("end_hold", pc, 32'h3FFC);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // reset during PEND discards target
    step(0, 1, 0, 0, 1, 32'h3800, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    check("rst_pend", pc, 32'h3004);

    // counter saturation
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 1, 32'h3000, 0, 0);
    check("cnt_ffff", 32'(redirect_cnt), 32'hFFFF);
    step(0, 0, 0, 0, 1, 32'h3000, 0, 0);
    check("cnt_sat", 32'(redirect_cnt), 32'hFFFF);

    // random
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15, rand_target(),
           $urandom_range(0, 99) < 10, rand_target(),
           $urandom_range(0, 99) < 10, rand_target());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller that owns the fetch address driven into the `ifu`. It chooses each cycle between sequential advance, branch, jump and jump-register redirects. It holds the PC under pipeline stall and remembers a redirect that arrives during a stall. It stops fetch on an illegal target, and sits between the decode-stage branch/jump resolution logic, the hazard unit and the instruction memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, first fetch address after reset; also the base of the IM window.
- `IM_WORDS`, 1024, IM depth in 32-bit words; the legal PC range is [RESET_PC, RESET_PC + 4*IM_WORDS).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold the PC this cycle (from the hazard unit).
- `br_req`  in  1  taken branch, single-cycle pulse.
- `br_target`  in  32  branch target.
- `j_req`  in  1  j/jal, pulse.
- `j_target`  in  32  jump target.
- `jr_req`  in  1  jr/jalr, pulse.
- `jr_target`  in  32  register target.
- `pc`  out  32  current fetch address to the IFU (registered).
- `pc_valid`  out  1  the fetched instruction at `pc` is usable.
- `redirect`  out  1  `pc` was loaded from a target on the last edge.
- `addr_err`  out  1  sticky illegal-address flag.
- `redirect_cnt`  out  16  saturating count of applied redirects.

## Operation
- Request priority: `jr_req` > `j_req` > `br_req`. The lower-priority requests in the same cycle are dropped.
- A target is legal when `target[1:0]==0` and it lies in the IM window.
- FSM states:
  - RUN:
    - No request, no stall: `pc <= pc+4`.
    - `stall`: `pc` holds.
    - Request with no stall: `pc <= target`, `redirect` pulses.
    - Request with `stall`: latch the winning target into `pend_target`, go to PEND, `pc` holds.
  - PEND:
    - While `stall` stays high: `pc` holds. A new request overwrites `pend_target` (latest wins).
    - When `stall` is low: `pc <= pend_target`, `redirect` pulses, return to RUN. A request in that same cycle is applied instead of `pend_target`.
  - HALT:
    - Entered when a target about to be loaded is illegal, or `pc+4` would leave the window.
    - `pc` holds its last legal value, `pc_valid=0`, `addr_err=1`.
    - Only `reset` exits HALT.
- The legality check runs at load time. An illegal target latched in PEND causes HALT only when it is applied.
- Delay slot: the request arrives while the delay-slot instruction is at `pc`, so the target is the very next `pc`. The sequencer never inserts a bubble.
- `redirect_cnt` increments on every `redirect` pulse and saturates at 16'hFFFF.

## Timing
- Reset values: `pc=RESET_PC`, `pc_valid=1` from the first cycle after reset, `redirect=0`, `addr_err=0`, `redirect_cnt=0`, state RUN, `pend_target=0`.
- Reset wins over every other input in the same cycle, including mid-PEND and in HALT.
- Latency:
  - A request sampled at edge n without stall appears on `pc` after edge n, with `redirect=1` for exactly that cycle.
  - `pc` changes at most once per edge.
  - `stall` has zero-cycle effect: the edge where `stall=1` does not change `pc`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Arithmetic:
  - `pc+4` is 32-bit unsigned.
  - The window end `RESET_PC+4*IM_WORDS` is computed 33 bits wide so 32-bit wrap-around cannot alias into the window.

## Structure
- Shared package `mips_defs` holds:
  - `RESET_PC_DEF`;
  - the state enum `seq_state_t` {RUN, PEND, HALT};
  - the redirect-source enum {SRC_SEQ, SRC_BR, SRC_J, SRC_JR};
  - `WORD_BYTES=4`.
- One combinational sub-module, `pc_range_chk` (inputs `addr`; output `legal`), is parameterised by `RESET_PC`/`IM_WORDS`. Two instances:
  - the selected target;
  - `pc+4`.
- The top level holds the FSM, the pend register, the PC register and the counter.

## Test plan
- Reset release then 4 free-running cycles → `pc` = 3000, 3004, 3008, 300C; `redirect=0`; `pc_valid=1`.
- At `pc`=3008, pulse `br_req` with target 3100 and no stall → next `pc`=3100 with `redirect=1` for one cycle, then 3104; `redirect_cnt`=1.
- Same-cycle `jr_req`(3200), `j_req`(3300) and `br_req`(3400) → next `pc`=3200.
- `stall` high for 3 cycles with `j_req`(3040) pulsed in cycle 1 → `pc` holds 3 cycles and the state is PEND. On the first cycle with `stall` low, the next `pc`=3040 and `redirect` pulses once.
- `br_req` with target 3102 (misaligned), and separately 0000_4000 (beyond 1024 words) → `pc` holds, `addr_err=1`, `pc_valid=0`. Further requests are ignored; `reset` restores `pc`=3000 and `addr_err=0`.
- `reset` asserted while in PEND with `stall=1` → the next cycle has `pc`=3000, state RUN and the pending target discarded. Separately, preload 65 535 redirects → `redirect_cnt` stays at FFFF after one more.
